serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..64).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: in_valid  input  1  operand request.
REQ-006 SHALL have port: in_ready  output  1  block idle, can accept operands.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: cin  input  1  carry-in.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: sum  output  WIDTH  result bits.
REQ-013 SHALL have port: cout  output  1  unsigned carry-out.
REQ-014 SHALL have port: ovf  output  1  two's-complement overflow.

Function
REQ-015 SHALL implement FSM states IDLE, ADD, DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in_valid=1 at a clock edge SHALL capture a, b and cin, clear the bit counter, and move to ADD.
REQ-017 In ADD, each cycle SHALL add one bit pair, LSB first, through one full-adder instance, with the carry held in a register seeded from cin.
REQ-018 In ADD, each sum bit SHALL shift into the sum register from the MSB end, and the operand registers SHALL shift right.
REQ-019 After exactly WIDTH ADD cycles the FSM SHALL move to DONE, so out_valid rises WIDTH cycles after the accepting edge.
REQ-020 On the final ADD cycle, cout SHALL register the full-adder carry-out and ovf SHALL register (carry into MSB) XOR (carry out of MSB).
REQ-021 In DONE, out_valid SHALL be 1; the FSM SHALL return to IDLE on the edge where out_ready=1.
REQ-022 Under backpressure (out_valid=1, out_ready=0), sum, cout and ovf SHALL hold stable.
REQ-023 in_ready SHALL be 0 in ADD and DONE, and in_valid SHALL be ignored there; there is no accept on the same edge as a result handoff.
REQ-024 sum, cout and ovf SHALL retain the last result after the return to IDLE until the next accept.
REQ-025 The result SHALL equal (a + b + cin) mod 2^(WIDTH+1) split as {cout, sum}.
REQ-026 With WIDTH=1, the block SHALL spend exactly one ADD cycle per operation.
REQ-027 The counter width SHALL be $clog2(WIDTH+1); the counter SHALL never wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE; sum, cout, ovf, the carry register, the counter and the operand registers to 0; out_valid=0; in_ready=1 (in_ready may be 0 only while rst_n is asserted if gated).
REQ-029 Reset asserted mid-ADD or in DONE SHALL abort the operation with no result presented; the first accept after deassertion SHALL behave as after power-up.

Structure
REQ-030 A shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE, ADD, DONE) and the constant DEFAULT_WIDTH=8.
REQ-031 The bit datapath SHALL instantiate the existing fulladder module as its single sub-module; no other arithmetic operator SHALL be used for the sum.

Verification
REQ-032 The bench SHALL cover WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, with out_valid high exactly 8 cycles after accept.
REQ-033 The bench SHALL cover a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 The bench SHALL cover a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
REQ-035 The bench SHALL cover out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; IDLE on the first out_ready=1 edge.
REQ-036 The bench SHALL cover rst_n pulsed after bit 3 of ADD -> all outputs 0 and in_ready=1; the next operation is correct.
REQ-037 The bench SHALL cover 1000 random operands, including WIDTH=1 and WIDTH=32 builds -> {cout, sum} matches a+b+cin and ovf matches the sign rule, with random out_ready backpressure.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the only arithmetic element of the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, with valid/ready
// handshakes on both the operand and the result side.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_e            state_r;
    state_e            state_n;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  acc_shift_s;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              fa_sum_s;
    logic              fa_cout_s;
    logic              last_s;

    fulladder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state decode and the shifted partial sum (new bit enters at the MSB).
    always_comb begin
        acc_shift_s            = acc_r >> 1'b1;
        acc_shift_s[WIDTH-1]   = fa_sum_s;
        last_s                 = (cnt_r == LAST);
        state_n                = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_n = ADD;
                else          state_n = IDLE;
            end
            ADD: begin
                if (last_s) state_n = DONE;
                else        state_n = ADD;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
                else           state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
        end
    end

    // Serial datapath; the result registers load only on the final bit so they
    // stay stable through ADD, DONE and the following IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                    end
                end
                ADD: begin
                    a_r     <= a_r >> 1'b1;
                    b_r     <= b_r >> 1'b1;
                    acc_r   <= acc_shift_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + ONE;
                    if (last_s) begin
                        sum_r  <= acc_shift_s;
                        cout_r <= fa_cout_s;
                        // carry_r is the carry into the MSB on the last step
                        ovf_r  <= carry_r ^ fa_cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus random traffic on
// WIDTH=8, WIDTH=1 and WIDTH=32 instances against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_g_n;
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    int          compared   = 0;
    int          mismatched = 0;
    bit          rand_bp    = 1'b0;
    logic [65:0] exp_q[$];
    logic [65:0] mon_e;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Reference: {ovf, cout, sum zero-extended to 64 bits}
    function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic c);
        logic [64:0] t;
        logic [63:0] m;
        logic        o;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x & m;
        y = y & m;
        t = {1'b0, x} + {1'b0, y} + {64'd0, c};
        o = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
        return {o, t[w], t[63:0] & m};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {65'd0, act}, {65'd0, exp});
    endtask

    task automatic check8_now(input string name, input logic [65:0] exp);
        check(name, {ovf, cout, 56'd0, sum}, exp);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int   n;
        logic took;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8, {56'd0, x}, {56'd0, y}, c));
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("latency8", 66'(n), 66'(8));
        took = 1'b0;
        n    = 0;
        while (!took && n < 1000) begin
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            took      = out_ready && out_valid;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        if (!took) begin
            compared++; mismatched++;
            $display("FAIL handoff8: got no handoff expected one within 1000 cycles");
        end
    endtask

    // Scoreboard monitor for the 8-bit instance
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL sb8: got unexpected result %0h expected none", sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb8", {ovf, cout, 56'd0, sum}, mon_e);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_w
        localparam int W = (g == 0) ? 1 : 32;
        logic          iv, ir, ov, ordy, ci, co, of;
        logic [W-1:0]  ga, gb, gs;
        logic [65:0]   q[$];
        logic [65:0]   me;
        bit            done = 1'b0;

        serial_adder #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_g_n), .in_valid(iv), .in_ready(ir),
            .a(ga), .b(gb), .cin(ci), .out_valid(ov), .out_ready(ordy),
            .sum(gs), .cout(co), .ovf(of)
        );

        // Random driver with random result backpressure
        initial begin
            logic [63:0] ra, rb;
            logic        rc, took;
            int          n;
            iv = 1'b0; ordy = 1'b0; ga = '0; gb = '0; ci = 1'b0;
            @(posedge rst_g_n);
            @(posedge clk); #1;
            for (int i = 0; i < 300; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rc = 1'($urandom);
                if (i < 4) begin
                    ra = (i[0]) ? 64'd0 : {64{1'b1}};
                    rb = (i[1]) ? {64{1'b1}} : 64'd0;
                end
                n = 0;
                while (!ir && n < 200) begin @(posedge clk); #1; n++; end
                ga = ra[W-1:0]; gb = rb[W-1:0]; ci = rc; iv = 1'b1;
                @(posedge clk);
                q.push_back(model(W, ra, rb, rc));
                #1;
                iv = 1'b0;
                took = 1'b0;
                n    = 0;
                while (!took && n < W + 1000) begin
                    ordy = 1'($urandom_range(0, 1));
                    took = ordy && ov;
                    @(posedge clk); #1;
                    n++;
                end
                ordy = 1'b0;
                if (!took) begin
                    compared++; mismatched++;
                    $display("FAIL handoff_w%0d: got no handoff expected one", W);
                end
            end
            done = 1'b1;
        end

        // Scoreboard monitor for this width
        always @(negedge clk) begin
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL sb_w%0d: got unexpected result expected none", W);
                end else begin
                    me = q.pop_front();
                    check($sformatf("sb_w%0d", W), {of, co, 64'(gs)}, me);
                end
            end
        end
    end

    initial begin
        int          n;
        logic [65:0] e;
        rst_n = 1'b0; rst_g_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check8_now("rst_result", 66'd0);
        @(negedge clk);
        rst_n = 1'b1; rst_g_n = 1'b1;
        @(posedge clk); #1;

        op8(8'hFF, 8'h01, 1'b0);
        check8_now("ff_plus_01", {1'b0, 1'b1, 56'd0, 8'h00});
        op8(8'h7F, 8'h01, 1'b0);
        check8_now("7f_plus_01", {1'b1, 1'b0, 56'd0, 8'h80});
        op8(8'h80, 8'h80, 1'b0);
        check8_now("80_plus_80", {1'b1, 1'b1, 56'd0, 8'h00});
        op8(8'h00, 8'h00, 1'b1);
        check8_now("00_plus_cin", {1'b0, 1'b0, 56'd0, 8'h01});

        // Backpressure: hold out_ready low in DONE while in_valid is asserted
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8, 64'h12, 64'h34, 1'b1));
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        e = {1'b0, 1'b0, 56'd0, 8'h47};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            check8_now("bp_hold", e);
            check1("bp_in_ready", in_ready, 1'b0);
            check1("bp_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check1("bp_release_in_ready", in_ready, 1'b1);
        check1("bp_release_out_valid", out_valid, 1'b0);
        check8_now("bp_retain", e);

        // Reset in the middle of ADD aborts the operation
        a = 8'hA5; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("midrst_in_ready", in_ready, 1'b1);
        check1("midrst_out_valid", out_valid, 1'b0);
        check8_now("midrst_result", 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'hA5, 8'h3C, 1'b1);
        check8_now("after_rst_op", {1'b0, 1'b0, 56'd0, 8'hE2});

        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        n = 0;
        while (!(g_w[0].done && g_w[1].done) && n < 60000) begin @(posedge clk); n++; end
        if (!(g_w[0].done && g_w[1].done)) begin
            compared++; mismatched++;
            $display("FAIL wide_done: got unfinished expected finished");
        end
        repeat (2) @(posedge clk);
        check("sb8_drained", 66'(exp_q.size()), 66'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
